// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard unit: tracked slot layout,
// select encoding and select width.
package fwd_pkg;

    // Slot rd storage is sized for the widest supported register address; narrower
    // addresses are zero-extended and the unused bits are trimmed in synthesis.
    localparam int RD_MAX_W = 8;

    localparam int SEL_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                we;
        logic                is_load;
    } slot_t;

    function automatic int fwd_sel_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Per-operand resolver: youngest matching slot wins, flags load-use hazards and
// muxes either the slot result or the register-file value.
module fwd_operand_sel
    import fwd_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int STAGES     = 3,
    parameter int LOAD_LAT   = 1,
    localparam int SEL_W     = fwd_sel_w(STAGES)
) (
    input  slot_t [STAGES-1:0]        slots,
    input  logic [REG_ADDR_W-1:0]     rs,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [STAGES*DATA_W-1:0]  stage_data,
    output logic [SEL_W-1:0]          sel,
    output logic                      hazard,
    output logic [DATA_W-1:0]         data
);

    logic found;

    always_comb begin
        sel    = SEL_W'(SEL_RF);
        hazard = 1'b0;
        data   = rf_data;
        found  = 1'b0;
        // Ascending scan with a found flag gives the youngest slot priority.
        for (int k = 0; k < STAGES; k++) begin
            if (!found && slots[k].valid && slots[k].we &&
                slots[k].rd == RD_MAX_W'(rs) && rs != '0) begin
                found  = 1'b1;
                sel    = SEL_W'(k + 1);
                hazard = slots[k].is_load && (k < LOAD_LAT);
                data   = stage_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID/EX forwarding and load-use hazard unit with an in-flight destination tracking pipe.
// Optional FWD_STATS_EN adds saturating stall/forward event counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int N_SRC      = 2,
    parameter int STAGES     = 3,
    parameter int LOAD_LAT   = 1,
    localparam int SEL_W     = fwd_sel_w(STAGES)
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_W-1:0]     issue_rd,
    input  logic                      issue_we,
    input  logic                      issue_is_load,
    input  logic [N_SRC*REG_ADDR_W-1:0] issue_rs,
    input  logic [N_SRC*DATA_W-1:0]   rf_data,
    input  logic [STAGES*DATA_W-1:0]  stage_data,
    input  logic                      flush,
    output logic                      stall,
    output logic [N_SRC*SEL_W-1:0]    fwd_sel,
    output logic [N_SRC*DATA_W-1:0]   opnd_out
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]               stat_stall_cnt,
    output logic [31:0]               stat_fwd_cnt
`endif
);

    slot_t [STAGES-1:0] slot_pipe;
    slot_t              issue_slot;
    logic [N_SRC-1:0]   hazard;

    for (genvar g = 0; g < N_SRC; g++) begin : g_opnd
        fwd_operand_sel #(
            .DATA_W    (DATA_W),
            .REG_ADDR_W(REG_ADDR_W),
            .STAGES    (STAGES),
            .LOAD_LAT  (LOAD_LAT)
        ) u_sel (
            .slots     (slot_pipe),
            .rs        (issue_rs[g*REG_ADDR_W +: REG_ADDR_W]),
            .rf_data   (rf_data[g*DATA_W +: DATA_W]),
            .stage_data(stage_data),
            .sel       (fwd_sel[g*SEL_W +: SEL_W]),
            .hazard    (hazard[g]),
            .data      (opnd_out[g*DATA_W +: DATA_W])
        );
    end

    // arst term lets stall fall in the same cycle reset is raised mid-stall.
    assign stall = issue_valid && !flush && !arst && (|hazard);

    always_comb begin
        issue_slot         = '0;
        issue_slot.valid   = 1'b1;
        issue_slot.rd      = RD_MAX_W'(issue_rd);
        issue_slot.we      = issue_we;
        issue_slot.is_load = issue_is_load;
    end

    // Downstream slots always advance; only slot 0 sees bubbles.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            slot_pipe <= '0;
        end else begin
            slot_pipe[0] <= (issue_valid && !stall && !flush) ? issue_slot : '0;
            for (int k = 1; k < STAGES; k++)
                slot_pipe[k] <= slot_pipe[k-1];
        end
    end

`ifdef FWD_STATS_EN
    logic fwd_evt;
    assign fwd_evt = issue_valid && !stall && (|fwd_sel);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stat_stall_cnt <= '0;
            stat_fwd_cnt   <= '0;
        end else begin
            if (stall && stat_stall_cnt != '1)
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            if (fwd_evt && stat_fwd_cnt != '1)
                stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed cycles push expectations,
// a negedge monitor pops and compares them.
module tb_fwd_hazard_unit;

    localparam int DATA_W = 64;
    localparam int RAW    = 5;
    localparam int NS     = 2;
    localparam int ST     = 3;
    localparam int SW     = 2;

    localparam logic [63:0] RF0 = 64'h1000;
    localparam logic [63:0] RF1 = 64'h2000;
    localparam logic [63:0] SD0 = 64'hAAAA;
    localparam logic [63:0] SD1 = 64'hBBBB;
    localparam logic [63:0] SD2 = 64'hCCCC;

    logic                   clk = 1'b0;
    logic                   arst;
    logic                   issue_valid;
    logic [RAW-1:0]         issue_rd;
    logic                   issue_we;
    logic                   issue_is_load;
    logic [NS*RAW-1:0]      issue_rs;
    logic [NS*DATA_W-1:0]   rf_data;
    logic [ST*DATA_W-1:0]   stage_data;
    logic                   flush;
    logic                   stall;
    logic [NS*SW-1:0]       fwd_sel;
    logic [NS*DATA_W-1:0]   opnd_out;
`ifdef FWD_STATS_EN
    logic [31:0]            stat_stall_cnt;
    logic [31:0]            stat_fwd_cnt;
`endif

    fwd_hazard_unit #(
        .DATA_W(DATA_W), .REG_ADDR_W(RAW), .N_SRC(NS), .STAGES(ST), .LOAD_LAT(1)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_we     (issue_we),
        .issue_is_load(issue_is_load),
        .issue_rs     (issue_rs),
        .rf_data      (rf_data),
        .stage_data   (stage_data),
        .flush        (flush),
        .stall        (stall),
        .fwd_sel      (fwd_sel),
        .opnd_out     (opnd_out)
`ifdef FWD_STATS_EN
        ,
        .stat_stall_cnt(stat_stall_cnt),
        .stat_fwd_cnt  (stat_fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        bit          cs;
        bit          st;
        bit          c0;
        logic [1:0]  s0;
        logic [63:0] d0;
        bit          c1;
        logic [1:0]  s1;
        logic [63:0] d1;
        bit          cst;
        logic [31:0] nstall;
        logic [31:0] nfwd;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus; called just after a posedge, returns just after the next.
    task automatic step(input string nm, input bit v, input int rd, input bit we, input bit ld,
                        input int rs0, input int rs1, input bit fl, input bit ar,
                        input bit cs, input bit st,
                        input bit c0, input int s0, input logic [63:0] d0,
                        input bit c1, input int s1, input logic [63:0] d1,
                        input bit cst, input int nst, input int nfw);
        exp_t e;
        issue_valid   = v;
        issue_rd      = RAW'(rd);
        issue_we      = we;
        issue_is_load = ld;
        issue_rs      = {RAW'(rs1), RAW'(rs0)};
        flush         = fl;
        arst          = ar;
        e.nm = nm; e.cs = cs; e.st = st;
        e.c0 = c0; e.s0 = 2'(s0); e.d0 = d0;
        e.c1 = c1; e.s1 = 2'(s1); e.d1 = d1;
        e.cst = cst; e.nstall = 32'(nst); e.nfwd = 32'(nfw);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.cs) chk({e.nm, ".stall"}, 64'(stall), 64'(e.st));
                if (e.c0) begin
                    chk({e.nm, ".sel0"}, 64'(fwd_sel[0 +: SW]), 64'(e.s0));
                    chk({e.nm, ".op0"}, opnd_out[0 +: DATA_W], e.d0);
                end
                if (e.c1) begin
                    chk({e.nm, ".sel1"}, 64'(fwd_sel[SW +: SW]), 64'(e.s1));
                    chk({e.nm, ".op1"}, opnd_out[DATA_W +: DATA_W], e.d1);
                end
`ifdef FWD_STATS_EN
                if (e.cst) begin
                    chk({e.nm, ".stat_stall"}, 64'(stat_stall_cnt), 64'(e.nstall));
                    chk({e.nm, ".stat_fwd"}, 64'(stat_fwd_cnt), 64'(e.nfwd));
                end
`endif
            end
        end
    end

    initial begin : stim
        int wait_cyc;
        arst = 1'b1; issue_valid = 0; issue_rd = '0; issue_we = 0; issue_is_load = 0;
        issue_rs = '0; flush = 0;
        rf_data    = {RF1, RF0};
        stage_data = {SD2, SD1, SD0};
        @(posedge clk);
        #1;
        //    name        v rd we ld rs0 rs1 fl ar  cs st  c0 s0 d0   c1 s1 d1   stats
        step("rst_idle",  1, 0, 0, 0,  3,  4, 0, 1, 1, 0, 1, 0, RF0, 1, 0, RF1, 1, 0, 0);
        step("idle",      1, 0, 0, 0,  3,  4, 0, 0, 1, 0, 1, 0, RF0, 1, 0, RF1, 0, 0, 0);
        step("alu_prod",  1, 5, 1, 0,  0,  0, 0, 0, 1, 0, 1, 0, RF0, 1, 0, RF1, 0, 0, 0);
        step("alu_fwd",   1, 0, 0, 0,  5,  3, 0, 0, 1, 0, 1, 1, SD0, 1, 0, RF1, 0, 0, 0);
        step("rd7_a",     1, 7, 1, 0,  0,  0, 0, 0, 1, 0, 1, 0, RF0, 1, 0, RF1, 0, 0, 0);
        step("rd7_b",     1, 7, 1, 0,  0,  0, 0, 0, 1, 0, 1, 0, RF0, 1, 0, RF1, 0, 0, 0);
        step("prio",      1, 0, 0, 0,  5,  7, 0, 0, 1, 0, 1, 0, RF0, 1, 1, SD0, 0, 0, 0);
        step("ld9",       1, 9, 1, 1,  0,  0, 0, 0, 1, 0, 1, 0, RF0, 1, 0, RF1, 0, 0, 0);
        step("ld_use",    1, 0, 0, 0,  9,  7, 0, 0, 1, 1, 0, 0, 0,   1, 3, SD2, 0, 0, 0);
        step("ld_fwd",    1, 0, 0, 0,  9,  7, 0, 0, 1, 0, 1, 2, SD1, 1, 0, RF1, 0, 0, 0);
        step("x0_prod",   1, 0, 1, 0,  0,  0, 0, 0, 1, 0, 1, 0, RF0, 1, 0, RF1, 0, 0, 0);
        step("x0_use",    1, 0, 0, 0,  0,  0, 0, 0, 1, 0, 1, 0, RF0, 1, 0, RF1, 0, 0, 0);
        step("ld9_b",     1, 9, 1, 1,  0,  0, 0, 0, 1, 0, 1, 0, RF0, 1, 0, RF1, 0, 0, 0);
        step("flush",     1, 9, 1, 0,  9,  3, 1, 0, 1, 0, 0, 0, 0,   1, 0, RF1, 0, 0, 0);
        step("flush_bub", 1, 11,1, 1,  9,  0, 0, 0, 1, 0, 1, 2, SD1, 1, 0, RF1, 0, 0, 0);
        step("no_valid",  0, 0, 0, 0, 11,  0, 0, 0, 1, 0, 0, 0, 0,   1, 0, RF1, 0, 0, 0);
        step("ld12",      1, 12,1, 1,  0,  0, 0, 0, 1, 0, 1, 0, RF0, 1, 0, RF1, 0, 0, 0);
        step("ld12_use",  1, 0, 0, 0, 12,  0, 0, 0, 1, 1, 0, 0, 0,   1, 0, RF1, 0, 0, 0);
        step("arst_mid",  1, 0, 0, 0, 12,  0, 0, 1, 1, 0, 1, 0, RF0, 1, 0, RF1, 1, 0, 0);
        step("post_rst",  1, 0, 0, 0, 12,  0, 0, 0, 1, 0, 1, 0, RF0, 1, 0, RF1, 0, 0, 0);
        step("s_ld9",     1, 9, 1, 1,  0,  0, 0, 0, 1, 0, 1, 0, RF0, 1, 0, RF1, 0, 0, 0);
        step("s_use",     1, 0, 0, 0,  9,  0, 0, 0, 1, 1, 0, 0, 0,   1, 0, RF1, 0, 0, 0);
        step("s_fwd",     1, 0, 0, 0,  9,  0, 0, 0, 1, 0, 1, 2, SD1, 1, 0, RF1, 0, 0, 0);
        step("s_alu5",    1, 5, 1, 0,  0,  0, 0, 0, 1, 0, 1, 0, RF0, 1, 0, RF1, 0, 0, 0);
        step("s_fwd5",    1, 6, 1, 0,  5,  0, 0, 0, 1, 0, 1, 1, SD0, 1, 0, RF1, 0, 0, 0);
        step("s_fwd6",    1, 0, 0, 0,  6,  0, 0, 0, 1, 0, 1, 1, SD0, 1, 0, RF1, 0, 0, 0);
        step("stats",     0, 0, 0, 0,  0,  0, 0, 0, 1, 0, 1, 0, RF0, 1, 0, RF1, 1, 1, 3);

        wait_cyc = 0;
        while (q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
